// File: rtl/traffic_lamp_driver.sv
// Lamp driver for the intersection sequencer: maps phase codes to lamps, blinks walker twinkle,
// and latches fail-safe flashing red on a filtered violation. LAMP_TEST_EN adds a lamp_test input.
module traffic_lamp_driver #(
  parameter int BLINK_HALF      = 1,
  parameter int CONFLICT_FILTER = 2,
  parameter int STARTUP_MASK    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] h_car_code,
  input  logic [2:0] v_car_code,
  input  logic [2:0] h_walker_code,
  input  logic [2:0] v_walker_code,
`ifdef LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  output logic [3:0] h_car_lamp,
  output logic [3:0] v_car_lamp,
  output logic [1:0] h_walker_lamp,
  output logic [1:0] v_walker_lamp,
  output logic       fault,
  output logic [1:0] fault_code
);

  // state  | meaning
  // NORMAL | lamps follow codes, monitor armed after startup mask
  // FAULT  | flashing red on cars, walkers red, held until reset

  localparam int SW = (STARTUP_MASK > 1) ? $clog2(STARTUP_MASK + 1) : 1;
  localparam int FW = (CONFLICT_FILTER > 1) ? $clog2(CONFLICT_FILTER + 1) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [2:0] C_RED  = 3'd0;
  localparam logic [2:0] C_TWNK = 3'd4;

  typedef enum logic {NORMAL, FAULT} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   su_cnt, su_cnt_n;
  logic [FW-1:0]   filt_cnt, filt_cnt_n;
  logic [BW-1:0]   hw_cnt, hw_cnt_n, vw_cnt, vw_cnt_n, fl_cnt, fl_cnt_n;
  logic            hw_ph, hw_ph_n, vw_ph, vw_ph_n, fl_ph, fl_ph_n;
  logic            hw_prev, hw_prev_n, vw_prev, vw_prev_n;
  logic [3:0]      h_car_lamp_n, v_car_lamp_n;
  logic [1:0]      h_walker_lamp_n, v_walker_lamp_n;
  logic            fault_n;
  logic [1:0]      fault_code_n;
  logic            v_inv, v_cc, v_cw, masked, lt;

`ifdef LAMP_TEST_EN
  assign lt = lamp_test;
`else
  assign lt = 1'b0;
`endif

  function automatic logic [3:0] car_map(input logic [2:0] c);
    case (c)
      3'd1:    car_map = 4'b0100;
      3'd2:    car_map = 4'b0010;
      3'd3:    car_map = 4'b1001;
      default: car_map = 4'b0001;
    endcase
  endfunction

  function automatic logic [1:0] walker_map(input logic [2:0] c, input logic ph);
    case (c)
      3'd1:    walker_map = 2'b10;
      3'd4:    walker_map = {ph, 1'b0};
      default: walker_map = 2'b01;
    endcase
  endfunction

  function automatic logic walker_bad(input logic [2:0] c);
    walker_bad = (c == 3'd2) || (c == 3'd3) || (c > 3'd4);
  endfunction

  always_comb begin
    v_inv = (h_car_code >= C_TWNK) || (v_car_code >= C_TWNK) ||
            walker_bad(h_walker_code) || walker_bad(v_walker_code);
    v_cc  = (h_car_code != C_RED) && (v_car_code != C_RED);
    v_cw  = ((h_car_code != C_RED) && (h_walker_code != C_RED)) ||
            ((v_car_code != C_RED) && (v_walker_code != C_RED));
    masked = su_cnt < SW'(STARTUP_MASK);
  end

  always_comb begin
    state_n         = state;
    su_cnt_n        = su_cnt;
    filt_cnt_n      = filt_cnt;
    hw_cnt_n        = hw_cnt;
    hw_ph_n         = hw_ph;
    hw_prev_n       = hw_prev;
    vw_cnt_n        = vw_cnt;
    vw_ph_n         = vw_ph;
    vw_prev_n       = vw_prev;
    fl_cnt_n        = fl_cnt;
    fl_ph_n         = fl_ph;
    fault_n         = fault;
    fault_code_n    = fault_code;
    h_car_lamp_n    = 4'b0001;
    v_car_lamp_n    = 4'b0001;
    h_walker_lamp_n = 2'b01;
    v_walker_lamp_n = 2'b01;

    case (state)
      NORMAL: begin
        if (masked) su_cnt_n = su_cnt + 1'b1;

        if (masked || !(v_inv || v_cc || v_cw)) begin
          filt_cnt_n = '0;
        end else if (filt_cnt == FW'(CONFLICT_FILTER - 1)) begin
          state_n      = FAULT;
          fault_n      = 1'b1;
          fault_code_n = v_inv ? 2'd3 : (v_cc ? 2'd1 : 2'd2);
          fl_cnt_n     = '0;
          fl_ph_n      = 1'b1;
          filt_cnt_n   = '0;
        end else begin
          filt_cnt_n = filt_cnt + 1'b1;
        end

        // Blink phase restarts green-on only on the first twinkle cycle.
        hw_prev_n = (h_walker_code == C_TWNK);
        if (hw_prev_n && !hw_prev) begin
          hw_cnt_n = '0;
          hw_ph_n  = 1'b1;
        end else if (hw_prev_n) begin
          if (hw_cnt == BW'(BLINK_HALF - 1)) begin
            hw_cnt_n = '0;
            hw_ph_n  = ~hw_ph;
          end else begin
            hw_cnt_n = hw_cnt + 1'b1;
          end
        end

        vw_prev_n = (v_walker_code == C_TWNK);
        if (vw_prev_n && !vw_prev) begin
          vw_cnt_n = '0;
          vw_ph_n  = 1'b1;
        end else if (vw_prev_n) begin
          if (vw_cnt == BW'(BLINK_HALF - 1)) begin
            vw_cnt_n = '0;
            vw_ph_n  = ~vw_ph;
          end else begin
            vw_cnt_n = vw_cnt + 1'b1;
          end
        end

        if (state_n == FAULT) begin
          h_car_lamp_n = 4'b0001;
          v_car_lamp_n = 4'b0001;
        end else if (lt) begin
          h_car_lamp_n    = 4'b1111;
          v_car_lamp_n    = 4'b1111;
          h_walker_lamp_n = 2'b11;
          v_walker_lamp_n = 2'b11;
        end else begin
          h_car_lamp_n    = car_map(h_car_code);
          v_car_lamp_n    = car_map(v_car_code);
          h_walker_lamp_n = walker_map(h_walker_code, hw_ph_n);
          v_walker_lamp_n = walker_map(v_walker_code, vw_ph_n);
        end
      end

      FAULT: begin
        if (fl_cnt == BW'(BLINK_HALF - 1)) begin
          fl_cnt_n = '0;
          fl_ph_n  = ~fl_ph;
        end else begin
          fl_cnt_n = fl_cnt + 1'b1;
        end
        h_car_lamp_n = {3'b000, fl_ph_n};
        v_car_lamp_n = {3'b000, fl_ph_n};
      end

      default: state_n = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= NORMAL;
      su_cnt        <= '0;
      filt_cnt      <= '0;
      hw_cnt        <= '0;
      hw_ph         <= 1'b0;
      hw_prev       <= 1'b0;
      vw_cnt        <= '0;
      vw_ph         <= 1'b0;
      vw_prev       <= 1'b0;
      fl_cnt        <= '0;
      fl_ph         <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= 2'd0;
      h_car_lamp    <= 4'b0001;
      v_car_lamp    <= 4'b0001;
      h_walker_lamp <= 2'b01;
      v_walker_lamp <= 2'b01;
    end else begin
      state         <= state_n;
      su_cnt        <= su_cnt_n;
      filt_cnt      <= filt_cnt_n;
      hw_cnt        <= hw_cnt_n;
      hw_ph         <= hw_ph_n;
      hw_prev       <= hw_prev_n;
      vw_cnt        <= vw_cnt_n;
      vw_ph         <= vw_ph_n;
      vw_prev       <= vw_prev_n;
      fl_cnt        <= fl_cnt_n;
      fl_ph         <= fl_ph_n;
      fault         <= fault_n;
      fault_code    <= fault_code_n;
      h_car_lamp    <= h_car_lamp_n;
      v_car_lamp    <= v_car_lamp_n;
      h_walker_lamp <= h_walker_lamp_n;
      v_walker_lamp <= v_walker_lamp_n;
    end
  end

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Bench for traffic_lamp_driver: directed scenarios plus random codes against a cycle-count model.
// Exercises lamp_test too when built with LAMP_TEST_EN.
module tb_traffic_lamp_driver;
  localparam int BH = 1;
  localparam int CF = 2;
  localparam int SM = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] h_car_code = 3'd0, v_car_code = 3'd0, h_walker_code = 3'd0, v_walker_code = 3'd0;
  logic       lamp_test = 1'b0;
  logic [3:0] h_car_lamp, v_car_lamp;
  logic [1:0] h_walker_lamp, v_walker_lamp;
  logic       fault;
  logic [1:0] fault_code;
  logic [14:0] obs;

  int checks = 0;
  int failures = 0;

  // model state: ages count cycles since an event, -1 meaning "not active"
  int since_reset, run, f_age, hw_age, vw_age;
  bit m_fault;
  logic [1:0] m_code;
  logic [14:0] exp_vec;

  traffic_lamp_driver #(.BLINK_HALF(BH), .CONFLICT_FILTER(CF), .STARTUP_MASK(SM)) dut (
    .clk(clk), .reset_n(reset_n),
    .h_car_code(h_car_code), .v_car_code(v_car_code),
    .h_walker_code(h_walker_code), .v_walker_code(v_walker_code),
`ifdef LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .h_car_lamp(h_car_lamp), .v_car_lamp(v_car_lamp),
    .h_walker_lamp(h_walker_lamp), .v_walker_lamp(v_walker_lamp),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;
  assign obs = {h_car_lamp, v_car_lamp, h_walker_lamp, v_walker_lamp, fault, fault_code};

  function automatic logic [3:0] m_car(input logic [2:0] c);
    if (c == 3'd1) return 4'b0100;
    if (c == 3'd2) return 4'b0010;
    if (c == 3'd3) return 4'b1001;
    return 4'b0001;
  endfunction

  function automatic logic [1:0] m_walk(input logic [2:0] c, input int age);
    if (c == 3'd1) return 2'b10;
    if (c == 3'd4) return (((age / BH) % 2) == 0) ? 2'b10 : 2'b00;
    return 2'b01;
  endfunction

  function automatic bit bad_w(input logic [2:0] c);
    return (c == 3'd2) || (c == 3'd3) || (c > 3'd4);
  endfunction

  task automatic model_reset();
    since_reset = 0; run = 0; f_age = 0; hw_age = -1; vw_age = -1;
    m_fault = 0; m_code = 2'd0;
    exp_vec = {4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0, 2'd0};
  endtask

  task automatic model_step(input logic [2:0] h, v, hw, vw, input bit lt);
    bit inv, cc, cw;
    logic [3:0] fl;
    if (m_fault) begin
      f_age++;
    end else begin
      inv = (h >= 3'd4) || (v >= 3'd4) || bad_w(hw) || bad_w(vw);
      cc  = (h != 0) && (v != 0);
      cw  = ((h != 0) && (hw != 0)) || ((v != 0) && (vw != 0));
      if (since_reset < SM || !(inv || cc || cw)) run = 0;
      else run++;
      if (run == CF) begin
        m_fault = 1; f_age = 0;
        m_code = inv ? 2'd3 : (cc ? 2'd1 : 2'd2);
      end
      hw_age = (hw == 3'd4) ? hw_age + 1 : -1;
      vw_age = (vw == 3'd4) ? vw_age + 1 : -1;
      if (since_reset < SM) since_reset++;
    end
    if (m_fault) begin
      fl = (((f_age / BH) % 2) == 0) ? 4'b0001 : 4'b0000;
      exp_vec = {fl, fl, 2'b01, 2'b01, 1'b1, m_code};
    end else if (lt) begin
      exp_vec = {4'b1111, 4'b1111, 2'b11, 2'b11, 1'b0, 2'd0};
    end else begin
      exp_vec = {m_car(h), m_car(v), m_walk(hw, hw_age), m_walk(vw, vw_age), 1'b0, 2'd0};
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    h_car_code = 3'($urandom_range(0, 7));
    v_car_code = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic step(input logic [2:0] h, v, hw, vw, input bit lt = 0);
    @(negedge clk);
    reset_n = 1'b1;
    h_car_code = h; v_car_code = v; h_walker_code = hw; v_walker_code = vw;
    lamp_test = lt;
`ifdef LAMP_TEST_EN
    model_step(h, v, hw, vw, lt);
`else
    model_step(h, v, hw, vw, 1'b0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 15'b0001_0001_01_01_0_00) begin
      failures++; $display("FAIL reset got=%b exp=%b", obs, 15'b0001_0001_01_01_0_00);
    end
  endtask

  task automatic test_mapping();
    do_reset();
    step(3'd1, 3'd0, 3'd0, 3'd1);
    checks++;
    if (obs !== {4'b0100, 4'b0001, 2'b01, 2'b10, 1'b0, 2'd0}) begin
      failures++; $display("FAIL map_green got=%b exp=%b", obs, {4'b0100, 4'b0001, 2'b01, 2'b10, 3'b000});
    end
    step(3'd0, 3'd3, 3'd1, 3'd0);
    checks++;
    if (obs !== exp_vec) begin failures++; $display("FAIL map_left got=%b exp=%b", obs, exp_vec); end
    step(3'd2, 3'd0, 3'd0, 3'd0);
    checks++;
    if (obs !== exp_vec) begin failures++; $display("FAIL map_yellow got=%b exp=%b", obs, exp_vec); end
  endtask

  task automatic test_twinkle();
    logic [1:0] want;
    step(3'd0, 3'd1, 3'd0, 3'd0);
    for (int i = 0; i < 6; i++) begin
      step(3'd0, 3'd1, 3'd4, 3'd0);
      want = (i % 2 == 0) ? 2'b10 : 2'b00;
      checks++;
      if (h_walker_lamp !== want || obs !== exp_vec) begin
        failures++; $display("FAIL twinkle[%0d] got=%b exp=%b", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_filter();
    logic [3:0] want;
    do_reset();
    repeat (3) step(3'd1, 3'd0, 3'd0, 3'd0);
    step(3'd1, 3'd1, 3'd0, 3'd0);
    step(3'd1, 3'd0, 3'd0, 3'd0);
    checks++;
    if (fault !== 1'b0 || obs !== exp_vec) begin
      failures++; $display("FAIL single_cycle_conflict got=%b exp=%b", obs, exp_vec);
    end
    step(3'd1, 3'd1, 3'd0, 3'd0);
    step(3'd1, 3'd1, 3'd0, 3'd0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || obs !== exp_vec) begin
      failures++; $display("FAIL cc_fault got=%b exp=%b", obs, exp_vec);
    end
    for (int k = 1; k <= 4; k++) begin
      step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      want = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      checks++;
      if (h_car_lamp !== want || v_car_lamp !== want || h_walker_lamp !== 2'b01 ||
          fault_code !== 2'd1 || obs !== exp_vec) begin
        failures++; $display("FAIL flash[%0d] got=%b exp=%b", k, obs, exp_vec);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    repeat (3) step(3'd0, 3'd0, 3'd1, 3'd1);
    step(3'd1, 3'd4, 3'd1, 3'd0);
    step(3'd1, 3'd4, 3'd1, 3'd0);
    checks++;
    if (fault_code !== 2'd3 || obs !== exp_vec) begin
      failures++; $display("FAIL priority got=%b exp=%b", obs, exp_vec);
    end
  endtask

  task automatic test_reset_mid_fault();
    do_reset();
    checks++;
    if (obs !== exp_vec) begin failures++; $display("FAIL fault_reset got=%b exp=%b", obs, exp_vec); end
    step(3'd0, 3'd1, 3'd1, 3'd0);
    checks++;
    if (fault !== 1'b0 || v_car_lamp !== 4'b0100 || obs !== exp_vec) begin
      failures++; $display("FAIL after_fault_reset got=%b exp=%b", obs, exp_vec);
    end
  endtask

  task automatic test_startup_mask();
    do_reset();
    step(3'd1, 3'd1, 3'd0, 3'd0);
    step(3'd1, 3'd1, 3'd0, 3'd0);
    step(3'd1, 3'd0, 3'd0, 3'd0);
    checks++;
    if (fault !== 1'b0 || obs !== exp_vec) begin
      failures++; $display("FAIL startup_mask got=%b exp=%b", obs, exp_vec);
    end
  endtask

`ifdef LAMP_TEST_EN
  task automatic test_lamp_test();
    do_reset();
    repeat (3) step(3'd0, 3'd0, 3'd0, 3'd0);
    step(3'd1, 3'd0, 3'd0, 3'd4, 1'b1);
    checks++;
    if (obs !== 15'b1111_1111_11_11_0_00) begin
      failures++; $display("FAIL lamp_test got=%b exp=%b", obs, 15'b1111_1111_11_11_0_00);
    end
    step(3'd1, 3'd0, 3'd0, 3'd4, 1'b0);
    checks++;
    if (obs !== exp_vec) begin failures++; $display("FAIL lamp_test_off got=%b exp=%b", obs, exp_vec); end
  endtask
`endif

  task automatic test_random();
    logic [2:0] h, v, hw, vw;
    int r;
    bit lt;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      lt = ($urandom_range(0, 9) == 0);
      if (r < 3) begin
        do_reset();
        checks++;
        if (obs !== exp_vec) begin failures++; $display("FAIL rand_reset[%0d] got=%b exp=%b", i, obs, exp_vec); end
        continue;
      end else if (r < 11) begin
        h = 3'($urandom_range(0, 7)); v = 3'($urandom_range(0, 7));
        hw = 3'($urandom_range(0, 7)); vw = 3'($urandom_range(0, 7));
      end else if (r < 17) begin
        h = 3'($urandom_range(1, 3)); v = 3'($urandom_range(0, 3));
        hw = 3'($urandom_range(0, 1)); vw = 3'd0;
      end else if ($urandom_range(0, 1) == 0) begin
        h = 3'($urandom_range(0, 3)); v = 3'd0; hw = 3'd0;
        vw = ($urandom_range(0, 2) == 2) ? 3'd4 : 3'($urandom_range(0, 1));
      end else begin
        v = 3'($urandom_range(0, 3)); h = 3'd0; vw = 3'd0;
        hw = ($urandom_range(0, 2) == 2) ? 3'd4 : 3'($urandom_range(0, 1));
      end
      step(h, v, hw, vw, lt);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL rand[%0d] got=%b exp=%b", i, obs, exp_vec); end
    end
  endtask

  initial begin
    test_reset();
    test_mapping();
    test_twinkle();
    test_filter();
    test_priority();
    test_reset_mid_fault();
    test_startup_mask();
`ifdef LAMP_TEST_EN
    test_lamp_test();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
